// File: rtl/mem_arbiter.sv
// Arbitrates CPU and front-panel requests onto a single 12-bit memory port.
// Three-state handshake (IDLE/BUSY/DONE) with round-robin tie-break and BUSY timeout.
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        btnCpuReset,
    input  logic        run,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [11:0] cpu_wdata,
    input  logic        cpu_read_type,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [11:0] cpu_rdata,
    input  logic        pnl_req,
    input  logic        pnl_we,
    input  logic [11:0] pnl_addr,
    input  logic [11:0] pnl_wdata,
    output logic        pnl_done,
    output logic        pnl_err,
    output logic [11:0] pnl_rdata,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [11:0] mem_address,
    output logic [11:0] mem_write_data,
    output logic        mem_read_type,
    input  logic [11:0] mem_read_data,
    input  logic        mem_finished
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        last_pnl, last_pnl_nxt;
    logic        owner_pnl, owner_pnl_nxt;
    logic [4:0]  tmo_cnt, tmo_cnt_nxt;
    logic        rd_en_nxt, wr_en_nxt, rtype_nxt;
    logic [11:0] addr_nxt, wdata_nxt;
    logic        cpu_done_nxt, cpu_err_nxt, pnl_done_nxt, pnl_err_nxt;
    logic [11:0] cpu_rdata_nxt, pnl_rdata_nxt, cap_rdata;
    logic        pnl_win, cpu_win, timed_out, finish;

    // Panel loses a tie only when it was the last one granted; CPU needs run=1.
    assign pnl_win   = (state == IDLE) && pnl_req && !(run && cpu_req && last_pnl);
    assign cpu_win   = (state == IDLE) && run && cpu_req && !pnl_win;
    assign timed_out = (tmo_cnt >= TMO_LAST);
    assign finish    = mem_finished || timed_out;
    assign cap_rdata = !mem_finished   ? 12'd0 :
                       mem_read_enable ? mem_read_data :
                       owner_pnl       ? pnl_rdata : cpu_rdata;

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            state            <= IDLE;
            last_pnl         <= 1'b0;
            owner_pnl        <= 1'b0;
            tmo_cnt          <= 5'd0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= 12'd0;
            mem_write_data   <= 12'd0;
            mem_read_type    <= 1'b0;
            cpu_done         <= 1'b0;
            cpu_err          <= 1'b0;
            cpu_rdata        <= 12'd0;
            pnl_done         <= 1'b0;
            pnl_err          <= 1'b0;
            pnl_rdata        <= 12'd0;
        end else begin
            state            <= state_nxt;
            last_pnl         <= last_pnl_nxt;
            owner_pnl        <= owner_pnl_nxt;
            tmo_cnt          <= tmo_cnt_nxt;
            mem_read_enable  <= rd_en_nxt;
            mem_write_enable <= wr_en_nxt;
            mem_address      <= addr_nxt;
            mem_write_data   <= wdata_nxt;
            mem_read_type    <= rtype_nxt;
            cpu_done         <= cpu_done_nxt;
            cpu_err          <= cpu_err_nxt;
            cpu_rdata        <= cpu_rdata_nxt;
            pnl_done         <= pnl_done_nxt;
            pnl_err          <= pnl_err_nxt;
            pnl_rdata        <= pnl_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pnl_win || cpu_win) state_nxt = BUSY;
            BUSY:    if (finish) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        last_pnl_nxt  = last_pnl;
        owner_pnl_nxt = owner_pnl;
        tmo_cnt_nxt   = tmo_cnt;
        rd_en_nxt     = mem_read_enable;
        wr_en_nxt     = mem_write_enable;
        addr_nxt      = mem_address;
        wdata_nxt     = mem_write_data;
        rtype_nxt     = mem_read_type;
        cpu_done_nxt  = 1'b0;
        cpu_err_nxt   = 1'b0;
        cpu_rdata_nxt = cpu_rdata;
        pnl_done_nxt  = 1'b0;
        pnl_err_nxt   = 1'b0;
        pnl_rdata_nxt = pnl_rdata;
        case (state)
            IDLE: begin
                if (pnl_win) begin
                    owner_pnl_nxt = 1'b1;
                    last_pnl_nxt  = 1'b1;
                    tmo_cnt_nxt   = 5'd0;
                    addr_nxt      = pnl_addr;
                    wdata_nxt     = pnl_wdata;
                    rtype_nxt     = 1'b0;
                    wr_en_nxt     = pnl_we;
                    rd_en_nxt     = !pnl_we;
                end else if (cpu_win) begin
                    owner_pnl_nxt = 1'b0;
                    last_pnl_nxt  = 1'b0;
                    tmo_cnt_nxt   = 5'd0;
                    addr_nxt      = cpu_addr;
                    wdata_nxt     = cpu_wdata;
                    rtype_nxt     = cpu_read_type;
                    wr_en_nxt     = cpu_we;
                    rd_en_nxt     = !cpu_we;
                end
            end
            BUSY: begin
                // A real completion wins over a timeout landing on the same edge.
                if (finish) begin
                    rd_en_nxt = 1'b0;
                    wr_en_nxt = 1'b0;
                    if (owner_pnl) begin
                        pnl_done_nxt  = 1'b1;
                        pnl_err_nxt   = !mem_finished;
                        pnl_rdata_nxt = cap_rdata;
                    end else begin
                        cpu_done_nxt  = 1'b1;
                        cpu_err_nxt   = !mem_finished;
                        cpu_rdata_nxt = cap_rdata;
                    end
                end else if (tmo_cnt != 5'h1F) begin
                    tmo_cnt_nxt = tmo_cnt + 5'd1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level reference model predicts grant
// order and responses; a monitor pops expectations whenever strobes or done pulses appear.
module tb_mem_arbiter;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        btnCpuReset, run;
    logic        cpu_req, cpu_we, cpu_read_type;
    logic [11:0] cpu_addr, cpu_wdata;
    logic        cpu_done, cpu_err;
    logic [11:0] cpu_rdata;
    logic        pnl_req, pnl_we;
    logic [11:0] pnl_addr, pnl_wdata;
    logic        pnl_done, pnl_err;
    logic [11:0] pnl_rdata;
    logic        mem_read_enable, mem_write_enable, mem_read_type;
    logic [11:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_finished, resp_fin, spur_fin;

    assign mem_finished = resp_fin | spur_fin;

    typedef struct {logic on; logic we; logic [11:0] addr; logic [11:0] wdata; logic rt; int lat;} req_t;
    typedef struct {logic we; logic [11:0] addr; logic [11:0] wdata; logic rt; logic chk_rt;} grant_t;
    typedef struct {logic is_pnl; logic err; logic [11:0] rdata; logic chk_rdata; int cycles;} done_t;

    grant_t      grant_q[$];
    done_t       done_q[$];
    int          lat_q[$];
    logic [11:0] mem_array [4096];
    logic [11:0] ref_mem [4096];
    logic        ref_last_pnl;
    int          checks = 0;
    int          errors = 0;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .btnCpuReset(btnCpuReset), .run(run),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_read_type(cpu_read_type), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .pnl_req(pnl_req), .pnl_we(pnl_we), .pnl_addr(pnl_addr), .pnl_wdata(pnl_wdata),
        .pnl_done(pnl_done), .pnl_err(pnl_err), .pnl_rdata(pnl_rdata),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read_type(mem_read_type),
        .mem_read_data(mem_read_data), .mem_finished(mem_finished)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic req_t mkReq(input logic on, input logic we, input logic [11:0] addr,
                                   input logic [11:0] wdata, input logic rt, input int lat);
        req_t r;
        r.on = on; r.we = we; r.addr = addr; r.wdata = wdata; r.rt = rt; r.lat = lat;
        return r;
    endfunction

    // Reference model: one granted transaction, in the order the arbitration rules dictate.
    task automatic predictGrant(input logic is_pnl, input req_t r, input logic expect_done);
        grant_t g;
        done_t  d;
        logic   tmo;
        tmo = (r.lat < 0);
        g.we = r.we; g.addr = r.addr; g.wdata = r.wdata; g.rt = r.rt; g.chk_rt = !is_pnl;
        d.is_pnl    = is_pnl;
        d.err       = tmo;
        d.chk_rdata = tmo || !r.we;
        d.rdata     = (tmo || r.we) ? 12'd0 : ref_mem[r.addr];
        d.cycles    = tmo ? TIMEOUT : r.lat + 1;
        if (expect_done && !tmo && r.we) ref_mem[r.addr] = r.wdata;
        grant_q.push_back(g);
        lat_q.push_back(r.lat);
        if (expect_done) done_q.push_back(d);
        ref_last_pnl = is_pnl;
    endtask

    task automatic waitDone(input logic is_pnl, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_pnl ? pnl_done : cpu_done) && n < 200);
        checkOutput(name, 32'(is_pnl ? pnl_done : cpu_done), 32'd1);
    endtask

    task automatic applyStimulus(input logic run_v, input req_t c, input req_t p);
        logic cpu_ok;
        cpu_ok = c.on && run_v;
        if (cpu_ok && p.on) begin
            if (ref_last_pnl) begin
                predictGrant(1'b0, c, 1'b1); predictGrant(1'b1, p, 1'b1);
            end else begin
                predictGrant(1'b1, p, 1'b1); predictGrant(1'b0, c, 1'b1);
            end
        end else if (cpu_ok) predictGrant(1'b0, c, 1'b1);
        else if (p.on) predictGrant(1'b1, p, 1'b1);
        @(negedge clk);
        run = run_v;
        cpu_req = c.on; cpu_we = c.we; cpu_addr = c.addr; cpu_wdata = c.wdata; cpu_read_type = c.rt;
        pnl_req = p.on; pnl_we = p.we; pnl_addr = p.addr; pnl_wdata = p.wdata;
        fork
            begin
                if (c.on) begin
                    if (run_v) waitDone(1'b0, "cpu_done_seen");
                    else repeat (20) @(negedge clk);
                    cpu_req = 1'b0;
                end
            end
            begin
                if (p.on) begin
                    waitDone(1'b1, "pnl_done_seen");
                    pnl_req = 1'b0;
                end
            end
        join
        repeat (2) @(negedge clk);
    endtask

    // Memory responder: completes each strobe after the latency queued by the model.
    initial begin
        int          lat;
        logic [11:0] a, wd;
        logic        w;
        resp_fin = 1'b0;
        mem_read_data = 12'd0;
        forever begin
            @(negedge clk);
            mem_read_data = 12'($urandom);
            if (mem_read_enable || mem_write_enable) begin
                lat = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
                a = mem_address; w = mem_write_enable; wd = mem_write_data;
                if (lat >= 0) begin
                    repeat (lat) @(negedge clk);
                    resp_fin = 1'b1;
                    if (w) mem_array[a] = wd;
                    else mem_read_data = mem_array[a];
                    @(negedge clk);
                    resp_fin = 1'b0;
                end else begin
                    while (mem_read_enable || mem_write_enable) @(negedge clk);
                end
            end
        end
    end

    // Monitor: pops grant expectations on strobe rise and done expectations on each pulse.
    initial begin
        grant_t g;
        done_t  d;
        logic   prev_strobe, strobe, have_g;
        int     scnt;
        prev_strobe = 1'b0; have_g = 1'b0; scnt = 0;
        forever begin
            @(negedge clk);
            strobe = mem_read_enable | mem_write_enable;
            if (strobe && !prev_strobe) begin
                scnt = 0;
                if (grant_q.size() == 0) begin
                    have_g = 1'b0;
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_grant: actual addr %0o, required no grant", mem_address);
                end else begin
                    g = grant_q.pop_front();
                    have_g = 1'b1;
                end
            end
            if (strobe && have_g) begin
                scnt++;
                checkOutput("strobe_overlap", 32'(mem_read_enable & mem_write_enable), 32'd0);
                checkOutput("mem_address", 32'(mem_address), 32'(g.addr));
                checkOutput("mem_write_enable", 32'(mem_write_enable), 32'(g.we));
                if (g.we) checkOutput("mem_write_data", 32'(mem_write_data), 32'(g.wdata));
                if (g.chk_rt) checkOutput("mem_read_type", 32'(mem_read_type), 32'(g.rt));
            end
            if (cpu_done || pnl_done) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_done: actual cpu %0b pnl %0b, required none", cpu_done, pnl_done);
                end else begin
                    d = done_q.pop_front();
                    checkOutput("done_owner", 32'({cpu_done, pnl_done}), d.is_pnl ? 32'd1 : 32'd2);
                    checkOutput("done_err", 32'(d.is_pnl ? pnl_err : cpu_err), 32'(d.err));
                    if (d.chk_rdata)
                        checkOutput("done_rdata", 32'(d.is_pnl ? pnl_rdata : cpu_rdata), 32'(d.rdata));
                    checkOutput("strobe_low_at_done", 32'(strobe), 32'd0);
                    checkOutput("busy_cycles", 32'(scnt), 32'(d.cycles));
                end
            end
            prev_strobe = strobe;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        req_t c, p;
        int   n, n_done, seen;
        btnCpuReset = 1'b1; run = 1'b0; spur_fin = 1'b0; ref_last_pnl = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'd0; cpu_wdata = 12'd0; cpu_read_type = 1'b0;
        pnl_req = 1'b0; pnl_we = 1'b0; pnl_addr = 12'd0; pnl_wdata = 12'd0;
        for (int i = 0; i < 4096; i++) begin
            mem_array[i] = 12'($urandom);
            ref_mem[i] = mem_array[i];
        end
        #1 btnCpuReset = 1'b0;
        #2;
        checkOutput("reset_strobes", 32'({mem_read_enable, mem_write_enable}), 32'd0);
        checkOutput("reset_done_err", 32'({cpu_done, cpu_err, pnl_done, pnl_err}), 32'd0);
        checkOutput("reset_mem_address", 32'(mem_address), 32'd0);
        checkOutput("reset_mem_wdata", 32'(mem_write_data), 32'd0);
        checkOutput("reset_rdata", 32'({cpu_rdata, pnl_rdata}), 32'd0);
        checkOutput("reset_read_type", 32'(mem_read_type), 32'd0);
        repeat (2) @(negedge clk);
        btnCpuReset = 1'b1;

        $display("[TB] tie with both requests held: expect alternation starting with panel");
        c = mkReq(1'b1, 1'b0, 12'o0100, 12'd0, 1'b1, 1);
        p = mkReq(1'b1, 1'b0, 12'o0300, 12'd0, 1'b0, 1);
        for (int k = 0; k < 6; k++) begin
            if (ref_last_pnl) predictGrant(1'b0, c, 1'b1);
            else predictGrant(1'b1, p, 1'b1);
        end
        @(negedge clk);
        run = 1'b1;
        cpu_req = 1'b1; cpu_we = c.we; cpu_addr = c.addr; cpu_read_type = c.rt;
        pnl_req = 1'b1; pnl_we = p.we; pnl_addr = p.addr;
        n = 0; n_done = 0;
        while (n_done < 6 && n < 300) begin
            @(negedge clk);
            n++;
            if (cpu_done || pnl_done) n_done++;
        end
        cpu_req = 1'b0; pnl_req = 1'b0;
        checkOutput("alternation_dones", 32'(n_done), 32'd6);
        repeat (2) @(negedge clk);

        $display("[TB] halted panel deposit");
        applyStimulus(1'b0, mkReq(1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 0),
                      mkReq(1'b1, 1'b1, 12'o0200, 12'o7402, 1'b0, 3));

        $display("[TB] CPU blocked while halted, then granted on run");
        mem_array[12'o0500] = 12'o1234;
        ref_mem[12'o0500] = 12'o1234;
        c = mkReq(1'b1, 1'b0, 12'o0500, 12'd0, 1'b0, 2);
        @(negedge clk);
        run = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = c.addr; cpu_read_type = c.rt;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_read_enable || mem_write_enable) seen++;
        end
        checkOutput("no_grant_while_halted", 32'(seen), 32'd0);
        predictGrant(1'b0, c, 1'b1);
        run = 1'b1;
        waitDone(1'b0, "cpu_done_after_run");
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] CPU read timeout");
        applyStimulus(1'b1, mkReq(1'b1, 1'b0, 12'o0777, 12'd0, 1'b1, -1),
                      mkReq(1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 0));

        $display("[TB] reset during BUSY");
        c = mkReq(1'b1, 1'b0, 12'o0700, 12'd0, 1'b0, -1);
        predictGrant(1'b0, c, 1'b0);
        @(negedge clk);
        run = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = c.addr; cpu_read_type = c.rt;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_read_enable && n < 20);
        checkOutput("reset_test_granted", 32'(mem_read_enable), 32'd1);
        repeat (3) @(negedge clk);
        #2 btnCpuReset = 1'b0;
        #1;
        checkOutput("midbusy_reset_strobes", 32'({mem_read_enable, mem_write_enable}), 32'd0);
        checkOutput("midbusy_reset_done", 32'({cpu_done, pnl_done}), 32'd0);
        ref_last_pnl = 1'b0;
        c.lat = 0;
        predictGrant(1'b0, c, 1'b1);
        @(negedge clk);
        btnCpuReset = 1'b1;
        @(negedge clk);
        checkOutput("regrant_first_edge", 32'(mem_read_enable), 32'd1);
        waitDone(1'b0, "regrant_done");
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] spurious mem_finished in IDLE, then zero-wait read");
        spur_fin = 1'b1;
        @(negedge clk);
        spur_fin = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, mkReq(1'b1, 1'b0, 12'o0042, 12'd0, 1'b0, 0),
                      mkReq(1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 0));

        $display("[TB] randomized traffic");
        for (int it = 0; it < 30; it++) begin
            c = mkReq(1'($urandom), 1'($urandom), 12'($urandom), 12'($urandom), 1'($urandom),
                      ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4)));
            p = mkReq(1'($urandom), 1'($urandom), 12'($urandom), 12'($urandom), 1'b0,
                      ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4)));
            applyStimulus(1'($urandom_range(0, 3) != 0), c, p);
        end

        repeat (5) @(negedge clk);
        checkOutput("queues_drained", 32'(grant_q.size() + done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum BUSY cycles allowed while waiting for mem_finished.
REQ-002 clk  in  1  single system clock; all state changes on the rising edge.
REQ-003 btnCpuReset  in  1  reset, asynchronous, active-low.
REQ-004 run  in  1  1 = program running; 0 = halted, panel-only access.
REQ-005 cpu_req, cpu_we  in  1,1  CPU request; write when cpu_we=1, read otherwise.
REQ-006 cpu_addr, cpu_wdata  in  12,12  CPU address and write data.
REQ-007 cpu_read_type  in  1  DATA_READ or instruction fetch, forwarded unchanged.
REQ-008 cpu_done, cpu_err  out  1,1  one-cycle completion pulse; error flag, valid with done.
REQ-009 cpu_rdata  out  12  CPU read data, valid while cpu_done=1.
REQ-010 pnl_req, pnl_we, pnl_addr, pnl_wdata  in  1,1,12,12  front-panel (deposit/examine) request.
REQ-011 pnl_done, pnl_err, pnl_rdata  out  1,1,12  panel completion pulse, error flag, read data.
REQ-012 mem_read_enable, mem_write_enable  out  1,1  memory strobes.
REQ-013 mem_address, mem_write_data  out  12,12  memory address and write data.
REQ-014 mem_read_type  out  1  read type forwarded to memory.
REQ-015 mem_read_data  in  12  memory read data.
REQ-016 mem_finished  in  1  memory completion, sampled on clk.

Function
REQ-017 FSM states SHALL be IDLE, BUSY and DONE; all outputs registered.
REQ-018 In IDLE, requests SHALL be sampled as follows:
- run=0: only pnl_req is eligible.
- run=1, one requester: that requester wins.
- run=1, both requesting: the requester not granted last wins; last-grant pointer resets to CPU, so panel wins the first tie.
REQ-019 IDLE->BUSY SHALL happen on the edge where a winner exists. Mem address, data, we and read_type are latched from the winner on that edge, and exactly one strobe asserts from it.
REQ-020 In BUSY, strobes and latched fields SHALL be held constant; requester inputs are ignored.
REQ-021 BUSY->DONE SHALL happen on the first edge with mem_finished=1:
- mem_read_data is captured into the winner's rdata (reads only).
- Strobes drop and the winner's done pulses high for exactly one cycle with err=0.
REQ-022 TIMEOUT abort: if mem_finished is not seen within TIMEOUT BUSY cycles, BUSY->DONE SHALL occur with strobes dropped, done=1, err=1, rdata=0.
REQ-023 DONE->IDLE SHALL be unconditional after one cycle; no request is sampled in DONE.
REQ-024 Minimum spacing: grants SHALL be at least 3 cycles apart; zero-wait memory gives strobe 1 cycle, done on the next.
REQ-025 Requester handshake: the requester SHALL hold req and fields until it samples done=1, then drop req; req still high in IDLE is a new request.
REQ-026 mem_finished in IDLE or DONE SHALL be ignored.
REQ-027 A run change during BUSY SHALL NOT abort the transfer; it affects only the next arbitration.
REQ-028 A requester dropping req during BUSY SHALL NOT abort the transfer; done still pulses.
REQ-029 Timeout counter SHALL be 5 bits, clear on IDLE->BUSY, and never wrap.

Reset
REQ-030 Assertion of btnCpuReset (low) SHALL immediately force:
- state IDLE;
- all strobes, done and err 0;
- mem_address, mem_write_data, rdata and mem_read_type 0;
- last-grant pointer CPU;
- timeout counter 0.
REQ-031 Reset during BUSY SHALL drop strobes without a done pulse; the first arbitration occurs on the first edge after deassertion.

Verification
REQ-032 run=0, pnl write 0o0200<-0o7402, mem_finished 3 cycles after strobe -> one write strobe, addr 0o0200, pnl_done 1 cycle, pnl_err=0.
REQ-033 run=1, cpu_req and pnl_req raised same cycle, both held -> panel granted first, CPU second, then alternation; no overlapping strobes.
REQ-034 run=0, cpu_req high 50 cycles -> no CPU grant; set run=1 -> CPU read granted, cpu_rdata = mem_read_data (e.g. 0o1234) with cpu_done.
REQ-035 CPU read, mem_finished never asserted -> cpu_done and cpu_err high after exactly 16 BUSY cycles, cpu_rdata=0, strobes low.
REQ-036 Reset pulsed mid-BUSY -> strobes low asynchronously, no done pulse; a still-held req is regranted after release.
REQ-037 Spurious mem_finished in IDLE, then zero-wait read -> spurious pulse ignored; strobe 1 cycle, done on the next cycle.
